// File: rtl/mzf_tape_player.sv
// rtl/mzf_tape_player.sv - Sharp MZ-80 PWM cassette waveform generator for MZF images
// Optional: define MZF_MOTOR_GATE_EN to pause playback while the motor input is low.
module mzf_tape_player #(
  parameter int LONG_HI  = 23200,
  parameter int LONG_LO  = 24700,
  parameter int SHORT_HI = 12000,
  parameter int SHORT_LO = 13200,
  parameter int GAP_HDR  = 22000,
  parameter int GAP_BODY = 11000,
  parameter int TM_HDR   = 40,
  parameter int TM_BODY  = 20
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       start,
  input  logic       motor,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       tape_out,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  typedef enum logic [3:0] {
    S_IDLE, S_GAP, S_TM_L, S_TM_S, S_SYNC, S_FETCH, S_BYTE, S_CKSUM, S_END, S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt, pidx, byte_cnt, body_len, cksum, sr;
  logic [3:0]  bcnt;
  logic        phase_body, ck_first;
  logic        run, pulse_st, cur_long, pulse_end, last_pulse, level, byte_last;
  logic [15:0] hi_len, tot_len, n_pulses, blk_len;

`ifdef MZF_MOTOR_GATE_EN
  assign run = motor;
`else
  assign run = motor | 1'b1;  // motor has no effect in this build
`endif

  function automatic logic [3:0] ones(input logic [7:0] b);
    ones = '0;
    for (int i = 0; i < 8; i++) ones = ones + {3'b000, b[i]};
  endfunction

  // Shape of the pulse currently being emitted and how many the state emits
  always_comb begin
    pulse_st = 1'b1;
    cur_long = 1'b0;
    n_pulses = 16'd1;
    case (state_q)
      S_GAP:   n_pulses = phase_body ? 16'(GAP_BODY) : 16'(GAP_HDR);
      S_TM_L:  begin cur_long = 1'b1; n_pulses = phase_body ? 16'(TM_BODY) : 16'(TM_HDR); end
      S_TM_S:  n_pulses = phase_body ? 16'(TM_BODY) : 16'(TM_HDR);
      S_SYNC:  cur_long = 1'b1;
      S_END:   cur_long = 1'b1;
      S_BYTE, S_CKSUM: cur_long = (bcnt == 4'd0) || sr[15];
      default: pulse_st = 1'b0;
    endcase
    hi_len  = cur_long ? 16'(LONG_HI) : 16'(SHORT_HI);
    tot_len = cur_long ? 16'(LONG_HI + LONG_LO) : 16'(SHORT_HI + SHORT_LO);
  end

  assign pulse_end  = pulse_st && run && (cnt == tot_len - 16'd1);
  assign last_pulse = (pidx == n_pulses - 16'd1);
  assign level      = pulse_st && (cnt < hi_len);
  assign byte_last  = (bcnt == 4'd8);
  assign blk_len    = phase_body ? body_len : 16'd128;

  always_comb begin
    state_d  = state_q;
    s_ready  = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      S_IDLE:  begin busy = 1'b0; if (start) state_d = S_GAP; end
      S_GAP:   if (pulse_end && last_pulse) state_d = S_TM_L;
      S_TM_L:  if (pulse_end && last_pulse) state_d = S_TM_S;
      S_TM_S:  if (pulse_end && last_pulse) state_d = S_SYNC;
      S_SYNC:  if (pulse_end) state_d = S_FETCH;
      S_FETCH: begin s_ready = 1'b1; if (s_valid) state_d = S_BYTE; end
      S_BYTE:  if (pulse_end && byte_last) state_d = (byte_cnt == blk_len) ? S_CKSUM : S_FETCH;
      S_CKSUM: if (pulse_end && byte_last && !ck_first) state_d = S_END;
      S_END:   if (pulse_end) state_d = (phase_body || body_len == 16'd0) ? S_FIN : S_GAP;
      S_FIN:   begin busy = 1'b0; done = 1'b1; state_d = S_IDLE; end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tape_out   <= 1'b0;
      underrun   <= 1'b0;
      cnt        <= '0;
      pidx       <= '0;
      bcnt       <= '0;
      sr         <= '0;
      cksum      <= '0;
      byte_cnt   <= '0;
      body_len   <= '0;
      phase_body <= 1'b0;
      ck_first   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tape_out <= level && run;
      // A stopped motor holds the counter at zero so the pulse restarts whole
      cnt  <= (!pulse_st || !run || pulse_end) ? 16'd0 : cnt + 16'd1;
      pidx <= (state_d != state_q) ? 16'd0 : (pulse_end ? pidx + 16'd1 : pidx);

      if (state_q == S_IDLE) begin
        phase_body <= 1'b0;
        body_len   <= '0;
        cksum      <= '0;
        byte_cnt   <= '0;
        bcnt       <= '0;
        if (start) underrun <= 1'b0;
      end

      if (state_q == S_END && pulse_end) begin
        phase_body <= 1'b1;
        cksum      <= '0;
        byte_cnt   <= '0;
      end

      if (state_q == S_FETCH) begin
        if (s_valid) begin
          sr       <= {s_data, 8'h00};
          byte_cnt <= byte_cnt + 16'd1;
          cksum    <= cksum + 16'(ones(s_data));
          if (!phase_body && byte_cnt == 16'h0012) body_len[7:0]  <= s_data;
          if (!phase_body && byte_cnt == 16'h0013) body_len[15:8] <= s_data;
        end else begin
          underrun <= 1'b1;
        end
      end

      // sr[15] is the bit on air; checksum bytes reuse the same shifter
      if ((state_q == S_BYTE || state_q == S_CKSUM) && pulse_end) begin
        if (bcnt != 4'd0) sr <= {sr[14:0], 1'b0};
        bcnt <= byte_last ? 4'd0 : bcnt + 4'd1;
        if (state_q == S_BYTE && byte_last && byte_cnt == blk_len) begin
          sr       <= cksum;
          ck_first <= 1'b1;
        end
        if (state_q == S_CKSUM && byte_last) ck_first <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mzf_tape_player.sv
// tb/tb_mzf_tape_player.sv - table-driven bench for mzf_tape_player
// Decodes tape_out back into long/short pulses and checks them against a reference model.
module tb_mzf_tape_player;
  localparam int LH = 4, LL = 4, SH = 2, SL = 2, GH = 3, GB = 2, TH = 2, TB = 1;
  localparam int HDR_PULSES = GH + 2 * TH + 1 + 128 * 9 + 18 + 1;
  localparam int HCK_IDX    = GH + 2 * TH + 1 + 128 * 9;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1, start = 1'b0, motor = 1'b1, s_valid;
  logic [7:0] s_data;
  logic       s_ready, tape_out, busy, done, underrun;

  always #5 clk_sys = ~clk_sys;

  mzf_tape_player #(
    .LONG_HI(LH), .LONG_LO(LL), .SHORT_HI(SH), .SHORT_LO(SL),
    .GAP_HDR(GH), .GAP_BODY(GB), .TM_HDR(TH), .TM_BODY(TB)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .motor(motor),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .tape_out(tape_out), .busy(busy), .done(done), .underrun(underrun)
  );

  typedef struct {
    logic [15:0] len;
    logic [7:0]  fill, b0, b1;
    int          stall;
    logic [15:0] exp_hck, exp_bck;
    int          exp_pulses;
    logic        exp_under;
  } vec_t;

  vec_t       vecs[4];
  int         n_vec = 0, n_bad = 0;
  logic [7:0] img[$];
  logic       pq[$], eq[$];
  int         hs_cnt = 0, stall_at = -1, stall_left = 0, stall_bad = 0, extra_ready = 0;
  int         dec_err = 0, hi_run = 0, lo_run = 0, done_cnt = 0;
  logic       pend = 1'b0, prev = 1'b0, allow_long = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte source with an optional stall of 50 ready cycles at one byte index
  initial begin
    s_valid = 1'b0;
    s_data  = 8'h00;
    forever begin
      @(negedge clk_sys);
      if (pend) hs_cnt++;
      if (s_ready && hs_cnt >= img.size()) extra_ready++;
      if (s_ready && hs_cnt == stall_at && stall_left > 0) begin
        stall_left--;
        if (tape_out !== 1'b0) stall_bad++;
        s_valid = 1'b0;
      end else begin
        s_valid = (hs_cnt < img.size());
        s_data  = s_valid ? img[hs_cnt] : 8'h00;
      end
      pend = s_valid && s_ready;
    end
  end

  // Pulse decoder: classifies each high run, bounds each low run
  initial begin
    int exp_lo;
    forever begin
      @(negedge clk_sys);
      if (done) done_cnt++;
      if (tape_out) begin
        if (!prev) begin
          if (pq.size() > 0) begin
            exp_lo = pq[$] ? LL : SL;
            if (lo_run < exp_lo || (lo_run > exp_lo + 1 && !allow_long)) dec_err++;
          end
          hi_run = 0;
        end
        hi_run++;
      end else begin
        if (prev) begin
          if (hi_run == LH) pq.push_back(1'b1);
          else if (hi_run == SH) pq.push_back(1'b0);
          else dec_err++;
          lo_run = 0;
        end
        lo_run++;
      end
      prev = tape_out;
    end
  end

  task automatic push_n(input int n, input logic v);
    for (int i = 0; i < n; i++) eq.push_back(v);
  endtask

  task automatic push_byte(input logic [7:0] b);
    eq.push_back(1'b1);
    for (int i = 7; i >= 0; i--) eq.push_back(b[i]);
  endtask

  task automatic push_block(input int gap, input int tm, input int first, input int cnt);
    logic [15:0] ck;
    ck = 16'd0;
    push_n(gap, 1'b0); push_n(tm, 1'b1); push_n(tm, 1'b0); eq.push_back(1'b1);
    for (int i = first; i < first + cnt; i++) begin
      push_byte(img[i]);
      for (int j = 0; j < 8; j++) ck = ck + 16'(img[i][j]);
    end
    push_byte(ck[15:8]); push_byte(ck[7:0]); eq.push_back(1'b1);
  endtask

  function automatic logic [7:0] dec_byte(input int k);
    logic [7:0] b;
    b = 8'hxx;
    if (k + 8 < pq.size()) for (int i = 0; i < 8; i++) b[7-i] = pq[k+1+i];
    return b;
  endfunction

  task automatic load_img(input vec_t v);
    img.delete();
    for (int i = 0; i < 128; i++) img.push_back(v.fill);
    img[18] = v.len[7:0];
    img[19] = v.len[15:8];
    if (v.len > 0) img.push_back(v.b0);
    if (v.len > 1) img.push_back(v.b1);
  endtask

  task automatic clear_mon(input vec_t v);
    hs_cnt = 0; pend = 1'b0; extra_ready = 0; stall_bad = 0;
    stall_at = v.stall; stall_left = 50; allow_long = (v.stall >= 0);
    pq.delete(); prev = 1'b0; lo_run = 0; hi_run = 0; dec_err = 0; done_cnt = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk_sys); reset = 1'b1;
    @(negedge clk_sys); reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit do_reset);
    logic [8:0] first9;
    int         first_bad;
    if (do_reset) pulse_reset();
    load_img(v);
    clear_mon(v);
    eq.delete();
    push_block(GH, TH, 0, 128);
    if (v.len != 0) push_block(GB, TB, 128, int'(v.len));
    @(negedge clk_sys); start = 1'b1;
    @(negedge clk_sys); start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_tape_low", tape_out, 1'b0);
    @(negedge clk_sys);
    chk("first_high", tape_out, 1'b1);
    for (int c = 0; c < 20000 && done_cnt == 0; c++) @(negedge clk_sys);
    repeat (5) @(negedge clk_sys);
    chk("done_once", done_cnt, 1);
    chk("busy_after", busy, 1'b0);
    chk("underrun", underrun, v.exp_under);
    chk("pulse_count", pq.size(), v.exp_pulses);
    first_bad = -1;
    for (int i = 0; i < pq.size() && i < eq.size(); i++)
      if (first_bad < 0 && pq[i] !== eq[i]) first_bad = i;
    chk("pulse_seq_first_diff", first_bad, -1);
    chk("pulse_timing_errs", dec_err, 0);
    first9 = 9'h1ff;
    if (pq.size() >= 9) for (int i = 0; i < 9; i++) first9[8-i] = pq[i];
    chk("leader_tm_sync_start", first9, 9'b000110011);
    chk("hdr_cksum", {dec_byte(HCK_IDX), dec_byte(HCK_IDX + 9)}, v.exp_hck);
    if (v.len != 0)
      chk("body_cksum", {dec_byte(HDR_PULSES + GB + 2 * TB + 1 + 9 * int'(v.len)),
                         dec_byte(HDR_PULSES + GB + 2 * TB + 10 + 9 * int'(v.len))}, v.exp_bck);
    chk("handshakes", hs_cnt, img.size());
    chk("ready_after_last", extra_ready, 0);
    chk("stall_tape_low", stall_bad, 0);
  endtask

  initial begin
    int z, h;
    vecs[0] = '{16'd2, 8'h00, 8'h80, 8'hFF, -1, 16'h0001, 16'h0009, 1221, 1'b0};
    vecs[1] = '{16'd0, 8'h00, 8'h00, 8'h00, -1, 16'h0000, 16'h0000, 1179, 1'b0};
    vecs[2] = '{16'd2, 8'h00, 8'h80, 8'hFF,  5, 16'h0001, 16'h0009, 1221, 1'b1};
    vecs[3] = '{16'd1, 8'hFF, 8'hA5, 8'h00, -1, 16'h03F1, 16'h0004, 1212, 1'b0};

    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("reset_state", {tape_out, busy, done, s_ready, underrun}, 5'b0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], 1'b1);

    // Reset in the middle of the body block, then replay without another reset
    pulse_reset();
    load_img(vecs[0]);
    clear_mon(vecs[0]);
    @(negedge clk_sys); start = 1'b1;
    @(negedge clk_sys); start = 1'b0;
    for (int c = 0; c < 20000 && hs_cnt < 130; c++) @(negedge clk_sys);
    chk("reached_body", hs_cnt >= 130, 1'b1);
    reset = 1'b1;
    @(negedge clk_sys); reset = 1'b0;
    chk("abort_tape", tape_out, 1'b0);
    chk("abort_busy", busy, 1'b0);
    repeat (20) @(negedge clk_sys);
    chk("abort_no_done", done_cnt, 0);
    run_vec(vecs[0], 1'b0);

`ifdef MZF_MOTOR_GATE_EN
    pulse_reset();
    load_img(vecs[3]);
    img[18] = 8'h00;
    img[19] = 8'h00;
    clear_mon(vecs[1]);
    @(negedge clk_sys); start = 1'b1;
    @(negedge clk_sys); start = 1'b0;
    for (int c = 0; c < 20000 && !(hs_cnt >= 3 && tape_out); c++) @(negedge clk_sys);
    motor = 1'b0;
    z = 0;
    repeat (10) begin @(negedge clk_sys); if (tape_out !== 1'b0) z++; end
    chk("motor_low_tape", z, 0);
    motor = 1'b1;
    h = 0;
    @(negedge clk_sys);
    while (tape_out && h < 20) begin h++; @(negedge clk_sys); end
    chk("motor_restart_full_hi", h, LH);
    for (int c = 0; c < 20000 && done_cnt == 0; c++) @(negedge clk_sys);
    chk("motor_done", done_cnt, 1);
    chk("motor_handshakes", hs_cnt, 128);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
